// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: local word RAM plus an MMIO window with a cycle counter,
// an LED register and a transmit FIFO drained over a valid/ready handshake.
module dmem_mmio_responder #(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] led,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        fifo_overflow
);

  localparam int unsigned RA = $clog2(RAM_WORDS);
  localparam int unsigned FA = $clog2(FIFO_DEPTH);

  localparam logic [7:0] OFS_CYCLE  = 8'h00;
  localparam logic [7:0] OFS_LED    = 8'h01;
  localparam logic [7:0] OFS_TXDATA = 8'h02;
  localparam logic [7:0] OFS_CTRL   = 8'h03;

  logic [31:0]   ram      [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [FA-1:0] wr_ptr;
  logic [FA-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   cycle_cnt;

  logic          is_ram;
  logic          is_mmio;
  logic [31:0]   status;
  logic [31:0]   rd_data;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          flush;
  logic          ovf_clr;
  logic          ovf_set;
  logic          cycle_wr;
  logic          led_wr;

  // Address decode and per-register strobes
  always_comb begin
    is_ram   = (address_dmem < 12'(RAM_WORDS));
    is_mmio  = (address_dmem[11:8] == 4'hF);
    full     = (count == CW'(FIFO_DEPTH));
    pop      = out_valid && out_ready;
    cycle_wr = wren && is_mmio && (address_dmem[7:0] == OFS_CYCLE);
    led_wr   = wren && is_mmio && (address_dmem[7:0] == OFS_LED);
    push_req = wren && is_mmio && (address_dmem[7:0] == OFS_TXDATA);
    ovf_clr  = wren && is_mmio && (address_dmem[7:0] == OFS_CTRL) && data[0];
    flush    = wren && is_mmio && (address_dmem[7:0] == OFS_CTRL) && data[1];
    // A full FIFO still takes the word when the head leaves in the same cycle
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
  end

  // Load mux; all sources are pre-edge values, giving read-before-write
  always_comb begin
    status     = 32'(count);
    status[31] = fifo_overflow;
    rd_data    = '0;
    if (is_ram) begin
      rd_data = ram[address_dmem[RA-1:0]];
    end else if (is_mmio) begin
      case (address_dmem[7:0])
        OFS_CYCLE:  rd_data = cycle_cnt;
        OFS_LED:    rd_data = led;
        OFS_TXDATA: rd_data = status;
        default:    rd_data = '0;
      endcase
    end
  end

  // Storage arrays are not cleared by reset
  always_ff @(posedge clock) begin
    if (reset && wren && is_ram) begin
      ram[address_dmem[RA-1:0]] <= data;
    end
    if (reset && push_ok) begin
      fifo_mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q_dmem        <= '0;
      led           <= '0;
      cycle_cnt     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      q_dmem    <= rd_data;
      cycle_cnt <= cycle_wr ? data : cycle_cnt + 32'(1);
      if (led_wr) begin
        led <= data;
      end

      if (ovf_clr) begin
        fifo_overflow <= 1'b0;
      end else if (ovf_set) begin
        fifo_overflow <= 1'b1;
      end

      // Flush discards everything, including a concurrent pop
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + FA'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + FA'(1);
        end
        if (push_ok && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push_ok) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = fifo_mem[rd_ptr];

endmodule
